// File: rtl/intc_pkg.sv
// Shared constants for the intc interrupt controller: register map and CAUSE layout.
package intc_pkg;

   localparam logic [1:0] INTC_PEND  = 2'd0;
   localparam logic [1:0] INTC_MASK  = 2'd1;
   localparam logic [1:0] INTC_CAUSE = 2'd2;
   localparam logic [1:0] INTC_SWI   = 2'd3;

   localparam int CAUSE_VALID_BIT = 15;
   localparam int CAUSE_IDX_W     = 4;

endpackage

// File: rtl/intc_edge.sv
// Per-source rising-edge detector with an optional 2-flop synchronizer in front.
// Macro INTC_SYNC_EN inserts the synchronizer (adds 2 cycles of latency).
module intc_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_src,
   output logic o_rise
);

   logic w_sample;
   logic r_src_q;

`ifdef INTC_SYNC_EN
   logic r_sync1;
   logic r_sync2;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_src;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sample = r_sync2;
`else
   assign w_sample = i_src;
`endif

   // src_q resets to 0 so a line held high through reset yields one edge afterwards.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_src_q <= 1'b0;
      else       r_src_q <= w_sample;
   end

   assign o_rise = w_sample & ~r_src_q;

endmodule

// File: rtl/intc.sv
// Interrupt controller top: PEND/MASK registers, fixed-priority CAUSE encoder, bus decode.
// Optional macro INTC_SYNC_EN adds source synchronizers inside intc_edge.
module intc
   import intc_pkg::*;
#(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src,
   input  logic [1:0]      addr,
   input  logic [15:0]     wdata,
   input  logic            wr,
   input  logic            rd,
   output logic [15:0]     rdata,
   output logic            irq
);

   logic [NSRC-1:0] r_pend;
   logic [NSRC-1:0] r_mask;
   logic [15:0]     r_rdata;

   logic [NSRC-1:0]        w_rise;
   logic [NSRC-1:0]        w_active;
   logic                   w_valid;
   logic [CAUSE_IDX_W-1:0] w_idx;
   logic [15:0]            w_cause;
   logic [15:0]            w_rd_mux;
   logic [NSRC-1:0]        w_wr_data;
   logic [NSRC-1:0]        w_set;
   logic [NSRC-1:0]        w_clr;
   logic                   w_unused;

   for (genvar g = 0; g < NSRC; g++) begin : g_edge
      intc_edge u_edge (
         .i_clk  (clk),
         .i_rst  (rst),
         .i_src  (src[g]),
         .o_rise (w_rise[g])
      );
   end

   assign w_wr_data = wdata[NSRC-1:0];
   assign w_unused  = &{1'b0, wdata[15:NSRC]};
   assign w_active  = r_pend & r_mask;
   assign w_valid   = |w_active;

   // Scan from the top down so the lowest set bit is the one left in w_idx.
   always_comb begin
      w_idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (w_active[i]) w_idx = CAUSE_IDX_W'(i);
      end
   end

   always_comb begin
      w_cause                    = '0;
      w_cause[CAUSE_VALID_BIT]   = w_valid;
      w_cause[CAUSE_IDX_W-1:0]   = w_idx;
   end

   always_comb begin
      w_rd_mux = '0;
      unique case (addr)
         INTC_PEND:  w_rd_mux = {{(16-NSRC){1'b0}}, r_pend};
         INTC_MASK:  w_rd_mux = {{(16-NSRC){1'b0}}, r_mask};
         INTC_CAUSE: w_rd_mux = w_cause;
         INTC_SWI:   w_rd_mux = '0;
         default:    w_rd_mux = '0;
      endcase
   end

   // Sets are applied after clears so a coincident set always survives.
   always_comb begin
      w_set = w_rise;
      w_clr = '0;
      if (wr && addr == INTC_SWI)  w_set = w_set | w_wr_data;
      if (wr && addr == INTC_PEND) w_clr = w_wr_data;
      if (rd && addr == INTC_CAUSE && w_valid)
         w_clr = w_clr | (NSRC'(1) << w_idx);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend  <= '0;
         r_mask  <= '0;
         r_rdata <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_set;
         if (wr && addr == INTC_MASK) r_mask  <= w_wr_data;
         if (rd)                      r_rdata <= w_rd_mux;
      end
   end

   assign rdata = r_rdata;
   assign irq   = w_valid;

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: directed scenarios followed by randomized traffic
// compared cycle by cycle against a behavioural model of the register semantics.
module tb_intc;
  import intc_pkg::*;

  localparam int NSRC = 8;
`ifdef INTC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] src;
  logic [1:0]      addr;
  logic [15:0]     wdata;
  logic            wr;
  logic            rd;
  logic [15:0]     rdata;
  logic            irq;

  int checks = 0;
  int errors = 0;

  intc #(.NSRC(NSRC)) dut (
    .clk   (clk),
    .rst   (rst),
    .src   (src),
    .addr  (addr),
    .wdata (wdata),
    .wr    (wr),
    .rd    (rd),
    .rdata (rdata),
    .irq   (irq)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model state
  logic [NSRC-1:0] m_pend;
  logic [NSRC-1:0] m_mask;
  logic [15:0]     m_rdata;
  logic [NSRC-1:0] m_hist[$];
  logic [15:0]     exp_q[$];

  function automatic logic [15:0] m_cause(logic [NSRC-1:0] p, logic [NSRC-1:0] m);
    for (int i = 0; i < NSRC; i++) begin
      if (p[i] && m[i]) return 16'h8000 | 16'(i);
    end
    return 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs currently driven, then compare.
  task automatic cycle();
    logic            was_rd;
    logic [NSRC-1:0] rise, set_b, clr_b;
    logic [15:0]     cause, rv;
    was_rd = 1'b0;
    if (rst) begin
      m_pend  = '0;
      m_mask  = '0;
      m_rdata = '0;
      m_hist.delete();
      for (int i = 0; i < SYNC_LAT + 2; i++) m_hist.push_back('0);
      exp_q.delete();
    end else begin
      m_hist.push_front(src);
      rise = m_hist[SYNC_LAT] & ~m_hist[SYNC_LAT+1];
      void'(m_hist.pop_back());
      cause = m_cause(m_pend, m_mask);
      if (rd) begin
        was_rd = 1'b1;
        case (addr)
          2'd0:    rv = 16'(m_pend);
          2'd1:    rv = 16'(m_mask);
          2'd2:    rv = cause;
          default: rv = 16'h0000;
        endcase
        exp_q.push_back(rv);
      end
      set_b = rise;
      clr_b = '0;
      if (wr && addr == 2'd3) set_b |= wdata[NSRC-1:0];
      if (wr && addr == 2'd0) clr_b = wdata[NSRC-1:0];
      if (rd && addr == 2'd2 && cause[15]) clr_b[cause[3:0]] = 1'b1;
      m_pend = (m_pend & ~clr_b) | set_b;
      if (wr && addr == 2'd1) m_mask = wdata[NSRC-1:0];
    end
    @(posedge clk);
    #1;
    if (was_rd && exp_q.size() > 0) m_rdata = exp_q.pop_front();
    chk("rdata", rdata, m_rdata);
    chk("irq", {15'b0, irq}, {15'b0, |(m_pend & m_mask)});
  endtask

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    addr = a; wdata = d; wr = 1'b1;
    cycle();
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    addr = a; rd = 1'b1;
    cycle();
    rd = 1'b0;
    d = rdata;
  endtask

  task automatic pulse(input logic [NSRC-1:0] b);
    src = src | b;
    cycle();
    src = src & ~b;
  endtask

  logic [15:0] rv;
  int          op;

  initial begin
    rst = 1'b1; src = '0; addr = '0; wdata = '0; wr = 1'b0; rd = 1'b0;
    idle(2);
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_irq", {15'b0, irq}, 16'h0000);
    rst = 1'b0;
    idle(2);

    // basic edge path
    bus_write(INTC_MASK, 16'h0001);
    pulse(8'h01);
    idle(SYNC_LAT);
    chk("edge_irq", {15'b0, irq}, 16'h0001);
    bus_read(INTC_CAUSE, rv);
    chk("edge_cause", rv, 16'h8000);
    chk("edge_irq_ack", {15'b0, irq}, 16'h0000);

    // priority and acknowledge order
    bus_write(INTC_MASK, 16'h00FF);
    pulse(8'h24);
    idle(SYNC_LAT);
    bus_read(INTC_CAUSE, rv);
    chk("prio_first", rv, 16'h8002);
    bus_read(INTC_CAUSE, rv);
    chk("prio_second", rv, 16'h8005);
    chk("prio_irq", {15'b0, irq}, 16'h0000);

    // masking
    bus_write(INTC_MASK, 16'h0000);
    pulse(8'h08);
    idle(SYNC_LAT + 1);
    bus_read(INTC_PEND, rv);
    chk("mask_pend", rv, 16'h0008);
    chk("mask_irq_off", {15'b0, irq}, 16'h0000);
    bus_write(INTC_MASK, 16'h0008);
    chk("mask_irq_on", {15'b0, irq}, 16'h0001);
    bus_write(INTC_PEND, 16'h0008);

    // set beats clear
    bus_write(INTC_MASK, 16'h0010);
    src[4] = 1'b1;
    idle(SYNC_LAT);
    bus_write(INTC_PEND, 16'h0010);
    chk("setclr_irq", {15'b0, irq}, 16'h0001);
    bus_read(INTC_PEND, rv);
    chk("setclr_pend", rv, 16'h0010);
    src[4] = 1'b0;
    bus_write(INTC_PEND, 16'h0010);
    idle(SYNC_LAT + 1);

    // software interrupt and empty CAUSE
    bus_write(INTC_MASK, 16'h0080);
    bus_write(INTC_SWI, 16'h0080);
    bus_read(INTC_CAUSE, rv);
    chk("swi_cause", rv, 16'h8007);
    bus_read(INTC_CAUSE, rv);
    chk("swi_empty", rv, 16'h0000);
    bus_read(INTC_PEND, rv);
    chk("swi_pend", rv, 16'h0000);
    bus_read(INTC_SWI, rv);
    chk("swi_read0", rv, 16'h0000);

    // reset mid-operation with src[1] held high
    bus_write(INTC_MASK, 16'h00FF);
    bus_write(INTC_SWI, 16'hFFFF);
    chk("pre_rst_irq", {15'b0, irq}, 16'h0001);
    src = 8'h02;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    idle(SYNC_LAT + 1);
    bus_read(INTC_PEND, rv);
    chk("rst_pend", rv, 16'h0002);
    bus_read(INTC_MASK, rv);
    chk("rst_mask", rv, 16'h0000);
    chk("rst_irq_after", {15'b0, irq}, 16'h0000);
    bus_write(INTC_PEND, 16'h0002);
    idle(3);
    bus_read(INTC_PEND, rv);
    chk("rst_one_edge", rv, 16'h0000);
    src = '0;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      src = src ^ (NSRC'($urandom) & NSRC'($urandom) & NSRC'($urandom));
      op = $urandom_range(0, 99);
      addr  = 2'($urandom_range(0, 3));
      wdata = 16'($urandom);
      if (addr == 2'd0 || addr == 2'd3) wdata = wdata & 16'($urandom);
      wr  = (op < 30) || (op >= 90 && op < 93);
      rd  = (op >= 30 && op < 65) || (op >= 90 && op < 93);
      rst = (op == 99);
      cycle();
      wr = 1'b0; rd = 1'b0; rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intc.md
# intc

Memory-mapped interrupt controller that drives the CPU's `irq` input. It collects up to `NSRC` peripheral interrupt lines, edge-detects and latches them into a pending register, and gates them with a software mask. It exposes a four-register word-addressed bus port. The CPU samples `irq` during fetch and vectors to its ISR; the ISR reads CAUSE to acknowledge the highest-priority source.

## Interface
Parameters:
- `NSRC`, default 8: number of interrupt sources; legal range 1..15.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `src`  in  NSRC  peripheral interrupt lines; a rising edge requests an interrupt.
- `addr`  in  2  word register select.
- `wdata`  in  16  write data.
- `wr`  in  1  write strobe, one cycle.
- `rd`  in  1  read strobe, one cycle.
- `rdata`  out  16  read data, registered.
- `irq`  out  1  interrupt request to the CPU.

## Operation
- Registers, selected by `addr`:
  - 0 PEND: read returns pending bits. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 1 MASK: read/write enable bits.
  - 2 CAUSE: read returns `{valid, 11'b0, idx[3:0]}`, where `idx` is the lowest-numbered bit set in PEND&MASK. A read with `valid`=1 clears `PEND[idx]`. A read with no source pending returns 0x0000 and clears nothing. Writes are ignored.
  - 3 SWI: writing 1 to a bit sets the matching PEND bit (software interrupt). Read returns 0.
- Bits `[15:NSRC]` read 0 and ignore writes.
- Edge detect: `src_q` holds the previous sample. A bit rises when `src & ~src_q`, and this sets the matching PEND bit.
- Set sources are edge and SWI; clear sources are the PEND write and the CAUSE read. When a set and a clear hit the same bit in the same cycle, set wins, so no edge is lost.
- `irq = |(PEND & MASK)`, driven combinationally from registers; no glitches between clock edges.
- Priority: fixed, bit 0 highest.
- `rd` and `wr` asserted together is illegal; if it happens, the write takes effect and `rdata` returns the pre-write value.
- Reset values: PEND=0, MASK=0, `src_q`=0, synchronizer flops=0, `rdata`=0x0000, `irq`=0.
- Reset mid-operation clears everything. A source held high through reset produces one edge after reset is released, because `src_q` resets to 0. This is intended.

## Timing
- Edge latency:
  - Cycle t: `src[i]` is first sampled high.
  - Edge t+1: PEND[i]=1.
  - `irq` rises in cycle t+1 if MASK[i]=1.
  - `INTC_SYNC_EN` adds 2 cycles.
- Read latency: `rd` in cycle t gives `rdata` valid in cycle t+1. `rdata` holds until the next read.
- CAUSE acknowledge: the clear takes effect at the edge ending the `rd` cycle. `irq` can drop in cycle t+1, which is before the CPU's next fetch sample.
- Write: takes effect at the edge ending the `wr` cycle. A MASK write changes `irq` in the next cycle.
- Back-to-back `rd` cycles are legal; each CAUSE read acknowledges a different source.

## Configuration
- Macro: `INTC_SYNC_EN`.
- Defined: each `src` bit passes through a 2-flop synchronizer before edge detect. Use this for asynchronous peripheral lines. Latency is +2 cycles.
- Undefined: `src` feeds edge detect directly. Sources must be synchronous to `clk`.

## Structure
- Package `intc_pkg`:
  - Address constants `INTC_PEND`, `INTC_MASK`, `INTC_CAUSE`, `INTC_SWI`.
  - `CAUSE_VALID_BIT`=15.
  - `CAUSE_IDX_W`=4.
- Sub-module `intc_edge`, one per source bit, generated:
  - Contains the optional synchronizer plus `src_q`.
  - Outputs a 1-cycle `rise` pulse.
- Top level holds PEND, MASK, the priority encoder, bus decode and `rdata`.

## Test plan
- Basic edge path:
  - Stimulus: MASK=0x0001; pulse `src[0]` for 1 cycle; read CAUSE.
  - Response: `irq`=1 at the stated latency; `rdata`=0x8000; `irq`=0 the cycle after the read.
- Priority and acknowledge order:
  - Stimulus: MASK=0x00FF; raise `src[5]` and `src[2]` together; issue two CAUSE reads.
  - Response: reads return 0x8002, then 0x8005; `irq`=0 afterwards.
- Masking:
  - Stimulus: MASK=0; pulse `src[3]`.
  - Response: PEND reads 0x0008; `irq`=0. Then write MASK=0x0008 → `irq`=1 the next cycle.
- Set beats clear:
  - Stimulus: write PEND=0x0010 in the same cycle that `src[4]` rises.
  - Response: PEND[4]=1; `irq` stays 1.
- Software interrupt and empty CAUSE:
  - Stimulus: write SWI=0x0080 with MASK=0x0080; read CAUSE twice.
  - Response: first read returns 0x8007; second read returns 0x0000; PEND=0.
- Reset mid-operation:
  - Stimulus: PEND=0x00FF and MASK=0x00FF; assert `rst` for 1 cycle while `src[1]` is held high.
  - Response: PEND, MASK and `irq` go to 0. After release, PEND[1] sets once and `irq` stays 0 because MASK=0.
